pc_fetch_sequencer: RTL

Sequences instruction fetch and program-counter update for the single-cycle RISC-V core, now that instruction memory has a request/acknowledge interface with variable latency. Owns the PC register, issues fetches, holds each instruction for exactly one execute window, and selects the next PC from sequential, branch (branch AND zero) or jump sources. Also flags fetch timeouts and misaligned targets and counts retired instructions.

---
 rtl/pc_fetch_sequencer_pkg.sv | 21 ++
 rtl/pc_fetch_sequencer_next_pc_sel.sv | 30 +++
 rtl/pc_fetch_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: datapath width, reset
// defaults, FSM state encoding and an alignment helper.
package pc_fetch_sequencer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_EXEC = 2'b10,
        ST_ERR  = 2'b11
    } fetch_state_e;

    // Instruction addresses must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_sel.sv
// Combinational next-PC selection: jump beats a taken branch, which beats
// the sequential pc+4. Also reports whether the chosen target is misaligned.
module pc_fetch_sequencer_next_pc_sel
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Priority mux for the redirect sources plus the alignment flag.
    always_comb begin
        next_pc    = pc + 32'd4;
        misaligned = 1'b0;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc + 32'd4;
        end
        misaligned = !is_word_aligned(next_pc);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/PC sequencer for the single-cycle core. Issues a level request to
// instruction memory, holds the returned word for one execute window, then
// advances the PC. Timeouts and misaligned targets park the block in a
// terminal error state until reset.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic            fetch_err,
    output logic [XLEN-1:0] retired_count
);

    // Wait counter only needs to reach TIMEOUT-1 before the error fires.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    fetch_state_e    state_r;
    logic [XLEN-1:0] pc_r;
    logic            imem_req_r;
    logic [XLEN-1:0] instr_r;
    logic            instr_valid_r;
    logic            fetch_err_r;
    logic [XLEN-1:0] retired_r;
    logic [TW-1:0]   tmo_r;
    logic [XLEN-1:0] next_pc_s;
    logic            misaligned_s;

    pc_fetch_sequencer_next_pc_sel u_next_pc_sel (
        .pc            (pc_r),
        .branch        (branch),
        .zero          (zero),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_pc       (next_pc_s),
        .misaligned    (misaligned_s)
    );

    // Fetch FSM with PC, retire counter, wait counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
            retired_r     <= 32'h0000_0000;
            tmo_r         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_REQ;
                    imem_req_r <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        tmo_r         <= '0;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_EXEC;
                    end else if (tmo_r == TMO_LAST) begin
                        imem_req_r  <= 1'b0;
                        fetch_err_r <= 1'b1;
                        state_r     <= ST_ERR;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                ST_EXEC: begin
                    if (stall) begin
                        state_r <= ST_EXEC;
                    end else if (misaligned_s) begin
                        instr_valid_r <= 1'b0;
                        fetch_err_r   <= 1'b1;
                        state_r       <= ST_ERR;
                    end else begin
                        pc_r          <= next_pc_s;
                        retired_r     <= retired_r + 32'd1;
                        instr_valid_r <= 1'b0;
                        imem_req_r    <= 1'b1;
                        state_r       <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    state_r       <= ST_ERR;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fetch_err_r   <= 1'b1;
                end
                default: begin
                    state_r       <= ST_ERR;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fetch_err_r   <= 1'b1;
                end
            endcase
        end
    end

    assign pc            = pc_r;
    assign imem_addr     = pc_r;
    assign imem_req      = imem_req_r;
    assign instr         = instr_r;
    assign instr_valid   = instr_valid_r;
    assign fetch_err     = fetch_err_r;
    assign retired_count = retired_r;

endmodule
